// File: rtl/ex_div_unit_if.sv
// Handshake/bus bundle between the EX stage and its multi-cycle divider.
// master = EX stage (issues operations), slave = ex_div_unit.
interface ex_div_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic                 start;
  logic                 signed_op;
  logic [WIDTH-1:0]     opdata1;
  logic [WIDTH-1:0]     opdata2;
  logic                 annul;
  logic                 hold;
  logic [2*WIDTH-1:0]   result;
  logic                 ready;
  logic                 stall_req;

  modport master (
    output start, signed_op, opdata1, opdata2, annul, hold,
    input  result, ready, stall_req
  );

  modport slave (
    input  start, signed_op, opdata1, opdata2, annul, hold,
    output result, ready, stall_req
  );
endinterface

// File: rtl/ex_div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU in the EX stage.
// result = {remainder, quotient}; stall_req freezes IF/ID/EX while iterating
// and drops in the END cycle so MEM latches the finished result.
// Optional macro DIV_FAST_EN: |dividend| < |divisor| finishes in 2 cycles.
module ex_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  ex_div_unit_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    FREE    = 2'd0,
    ON      = 2'd1,
    DIVZERO = 2'd2,
    END     = 2'd3
  } state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [WIDTH-1:0]     dvd;      // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0]     dvs;
  logic [WIDTH-1:0]     rem;
  logic                 neg_q;
  logic                 neg_r;
  logic [2*WIDTH-1:0]   result_r;
  logic                 ready_r;

  logic [WIDTH-1:0]     abs_a;
  logic [WIDTH-1:0]     abs_b;
  logic [WIDTH:0]       trial_shift;
  logic [WIDTH:0]       trial_diff;
  logic [WIDTH-1:0]     rem_next;
  logic [WIDTH-1:0]     quo_next;
  logic [WIDTH-1:0]     q_fix;
  logic [WIDTH-1:0]     r_fix;
  logic                 qbit;

`ifdef DIV_FAST_EN
  logic                 fast;
  logic [WIDTH-1:0]     fast_rem;
`endif

  // Operand magnitudes, one restoring step, and final sign fix-up.
  always_comb begin
    abs_a = (bus.signed_op && bus.opdata1[WIDTH-1]) ? -bus.opdata1 : bus.opdata1;
    abs_b = (bus.signed_op && bus.opdata2[WIDTH-1]) ? -bus.opdata2 : bus.opdata2;
    trial_shift = {rem, dvd[WIDTH-1]};
    trial_diff  = trial_shift - {1'b0, dvs};
    qbit        = ~trial_diff[WIDTH];
    rem_next    = qbit ? trial_diff[WIDTH-1:0] : trial_shift[WIDTH-1:0];
    quo_next    = {dvd[WIDTH-2:0], qbit};
    q_fix       = neg_q ? -quo_next : quo_next;
    r_fix       = neg_r ? -rem_next : rem_next;
  end

  // Freeze request: asserted from the accept cycle until the result is ready.
  always_comb begin
    bus.stall_req = ((state == FREE) && bus.start) || (state == ON) || (state == DIVZERO);
  end

  assign bus.result = result_r;
  assign bus.ready  = ready_r;

  // Divider FSM with registered result/ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FREE;
      cnt      <= '0;
      dvd      <= '0;
      dvs      <= '0;
      rem      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_r <= '0;
      ready_r  <= 1'b0;
`ifdef DIV_FAST_EN
      fast     <= 1'b0;
      fast_rem <= '0;
`endif
    end else if (bus.annul) begin
      // Flush: in FREE this only blocks acceptance; elsewhere it drops the result.
      if (state != FREE) begin
        result_r <= '0;
      end
      state   <= FREE;
      ready_r <= 1'b0;
    end else begin
      case (state)
        FREE: begin
          ready_r <= 1'b0;
          if (bus.start) begin
            dvd   <= abs_a;
            dvs   <= abs_b;
            rem   <= '0;
            cnt   <= '0;
            neg_q <= bus.signed_op && (bus.opdata1[WIDTH-1] ^ bus.opdata2[WIDTH-1]);
            neg_r <= bus.signed_op && bus.opdata1[WIDTH-1];
`ifdef DIV_FAST_EN
            fast     <= (bus.opdata2 != '0) && (abs_a < abs_b);
            fast_rem <= bus.opdata1;
            if ((bus.opdata2 == '0) || (abs_a < abs_b)) begin
              state <= DIVZERO;
            end else begin
              state <= ON;
            end
`else
            if (bus.opdata2 == '0) begin
              state <= DIVZERO;
            end else begin
              state <= ON;
            end
`endif
          end
        end
        ON: begin
          dvd <= quo_next;
          rem <= rem_next;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            result_r <= {r_fix, q_fix};
            ready_r  <= 1'b1;
            state    <= END;
          end
        end
        DIVZERO: begin
`ifdef DIV_FAST_EN
          result_r <= fast ? {fast_rem, {WIDTH{1'b0}}} : '0;
`else
          result_r <= '0;
`endif
          ready_r <= 1'b1;
          state   <= END;
        end
        END: begin
          if (bus.hold) begin
            ready_r <= 1'b1;
          end else begin
            ready_r <= 1'b0;
            state   <= FREE;
          end
        end
        default: begin
          ready_r <= 1'b0;
          state   <= FREE;
        end
      endcase
    end
  end

endmodule
